// File: rtl/labs_energy_pkg.sv
// rtl/labs_energy_pkg.sv - shared FSM encoding and energy-width helper for labs_energy
package labs_energy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed for the worst-case energy of an all-equal sequence: sum (N-k)^2.
    function automatic int max_energy_width(input int n);
        int e_max;
        e_max = (n * (n - 1) * (2 * n - 1)) / 6;
        return $clog2(e_max + 1);
    endfunction

endpackage

// File: rtl/labs_energy_corr_lag.sv
// rtl/labs_energy_corr_lag.sv - combinational aperiodic autocorrelation term C_k
module corr_lag
    import labs_energy_pkg::*;
#(
    parameter int SEQ_WIDTH = 8,
    parameter int CK_WIDTH  = 8,
    parameter int LAG_WIDTH = 4
) (
    input  logic [SEQ_WIDTH-1:0]       i_seq,
    input  logic [LAG_WIDTH-1:0]       i_lag,
    output logic signed [CK_WIDTH-1:0] o_ck
);

    logic [SEQ_WIDTH-1:0] w_match;
    int                   w_sum;

    // Bit i of w_match is set when element i agrees with element i+lag.
    assign w_match = ~(i_seq ^ (i_seq >> i_lag));

    always_comb begin
        w_sum = 0;
        for (int i = 0; i < SEQ_WIDTH; i++) begin
            if (i < SEQ_WIDTH - int'(i_lag)) begin
                w_sum = w_sum + (w_match[i] ? 1 : -1);
            end
        end
        o_ck = CK_WIDTH'(w_sum);
    end

endmodule

// File: rtl/labs_energy.sv
// rtl/labs_energy.sv - sequential LABS energy evaluator with best-so-far record
module labs_energy
    import labs_energy_pkg::*;
#(
    parameter int SEQ_WIDTH = 8,
    parameter int CK_WIDTH  = 8,
    parameter int E_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEQ_WIDTH-1:0] in_seq,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [E_WIDTH-1:0]   out_energy,
    output logic [SEQ_WIDTH-1:0] out_seq,
    input  logic                 clear_best,
    output logic                 best_valid,
    output logic [E_WIDTH-1:0]   best_energy,
    output logic [SEQ_WIDTH-1:0] best_seq
);

    localparam int             K_W    = $clog2(SEQ_WIDTH + 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(SEQ_WIDTH);

    if (SEQ_WIDTH < 2 || SEQ_WIDTH > 64) begin : g_bad_seq_width
        $error("labs_energy: SEQ_WIDTH must be 2..64");
    end
    if (E_WIDTH < max_energy_width(SEQ_WIDTH)) begin : g_bad_e_width
        $error("labs_energy: E_WIDTH too narrow for worst-case energy");
    end
    if (CK_WIDTH < $clog2(SEQ_WIDTH) + 1) begin : g_bad_ck_width
        $error("labs_energy: CK_WIDTH too narrow for C_k");
    end

    state_t                        r_state;
    state_t                        w_next;
    logic [SEQ_WIDTH-1:0]          r_seq;
    logic [K_W-1:0]                r_k;
    logic [E_WIDTH-1:0]            r_acc;
    logic [E_WIDTH-1:0]            r_sq;
    logic [E_WIDTH-1:0]            r_out_energy;
    logic [SEQ_WIDTH-1:0]          r_out_seq;
    logic                          r_best_valid;
    logic [E_WIDTH-1:0]            r_best_energy;
    logic [SEQ_WIDTH-1:0]          r_best_seq;
    logic signed [CK_WIDTH-1:0]    w_ck;
    logic signed [2*CK_WIDTH-1:0]  w_ck_ext;
    logic signed [2*CK_WIDTH-1:0]  w_sq;
    logic [E_WIDTH-1:0]            w_energy;
    logic                          w_accept;
    logic                          w_finish;
    logic                          w_release;

    corr_lag #(
        .SEQ_WIDTH (SEQ_WIDTH),
        .CK_WIDTH  (CK_WIDTH),
        .LAG_WIDTH (K_W)
    ) u_corr_lag (
        .i_seq (r_seq),
        .i_lag (r_k),
        .o_ck  (w_ck)
    );

    assign w_ck_ext  = {{CK_WIDTH{w_ck[CK_WIDTH-1]}}, w_ck};
    assign w_sq      = w_ck_ext * w_ck_ext;
    assign w_energy  = r_acc + r_sq;
    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    // Squares run one stage ahead of the sum, so the final add lands on the edge after lag N-1.
    assign w_finish  = (r_state == ST_RUN) && (r_k == K_LAST);
    assign w_release = (r_state == ST_DONE) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_next = ST_RUN;
            ST_RUN:  if (w_finish)  w_next = ST_DONE;
            ST_DONE: if (w_release) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq         <= '0;
            r_k           <= '0;
            r_acc         <= '0;
            r_sq          <= '0;
            r_out_energy  <= '0;
            r_out_seq     <= '0;
            r_best_valid  <= 1'b0;
            r_best_energy <= '0;
            r_best_seq    <= '0;
        end else begin
            if (w_accept) begin
                r_seq <= in_seq;
                r_k   <= K_W'(1);
                r_acc <= '0;
                r_sq  <= '0;
            end else if ((r_state == ST_RUN) && !w_finish) begin
                r_sq  <= E_WIDTH'($unsigned(w_sq));
                r_acc <= w_energy;
                r_k   <= r_k + K_W'(1);
            end

            if (w_finish) begin
                r_out_energy <= w_energy;
                r_out_seq    <= r_seq;
            end

            // A clear on the same edge as a finishing result discards that result.
            if (clear_best) begin
                r_best_valid <= 1'b0;
            end else if (w_finish && (!r_best_valid || (w_energy < r_best_energy))) begin
                r_best_valid  <= 1'b1;
                r_best_energy <= w_energy;
                r_best_seq    <= r_seq;
            end
        end
    end

    assign out_energy  = r_out_energy;
    assign out_seq     = r_out_seq;
    assign best_valid  = r_best_valid;
    assign best_energy = r_best_energy;
    assign best_seq    = r_best_seq;

endmodule

// File: doc/labs_energy.md
LABS_ENERGY -- requirements
Module: labs_energy

Interface
REQ-001 SHALL have parameter SEQ_WIDTH, default 8, sequence length N; legal range 2..64.
REQ-002 SHALL have parameter CK_WIDTH, default 8, signed width of one correlation term C_k.
REQ-003 SHALL have parameter E_WIDTH, default 16, unsigned width of the energy result.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, candidate sequence offered.
REQ-007 SHALL have port in_ready, output, 1, block can accept a sequence.
REQ-008 SHALL have port in_seq, input, SEQ_WIDTH, candidate sequence; bit 1 = +1, bit 0 = -1.
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port out_energy, output, E_WIDTH, E = sum over k=1..N-1 of C_k squared.
REQ-012 SHALL have port out_seq, output, SEQ_WIDTH, sequence that produced out_energy.
REQ-013 SHALL have port clear_best, input, 1, invalidates the best-so-far record.
REQ-014 SHALL have port best_valid, output, 1, best record holds a result.
REQ-015 SHALL have port best_energy, output, E_WIDTH, lowest energy seen since reset or clear.
REQ-016 SHALL have port best_seq, output, SEQ_WIDTH, sequence owning best_energy.

Function
REQ-017 SHALL compute C_k as the sum over i=0..N-1-k of +1 if in_seq[i]==in_seq[i+k] else -1, in two's complement CK_WIDTH.
REQ-018 SHALL use an FSM with states IDLE, RUN, DONE.
REQ-019 IDLE: in_ready=1; on in_valid&in_ready, register in_seq, set lag k=1, clear accumulator, go to RUN.
REQ-020 RUN: one lag per cycle, acc += C_k*C_k; k increments; after k=N-1 is accumulated, go to DONE; in_ready=0.
REQ-021 DONE: out_valid=1; out_energy/out_seq stable until out_valid&out_ready; then go to IDLE.
REQ-022 Latency: out_valid SHALL rise exactly N clock edges after the accepting edge (8 for N=8); no new input is accepted before the output handshake completes.
REQ-023 The accumulator SHALL be at least E_WIDTH bits wide and SHALL never wrap, because E_WIDTH >= clog2(N(N-1)(2N-1)/6 + 1) is required; a violating parameter set SHALL fail elaboration.
REQ-024 The best record SHALL update on the edge entering DONE if best_valid=0 or the new E is strictly less than best_energy; ties keep the earlier sequence.
REQ-025 clear_best SHALL set best_valid=0 on the next edge; if it coincides with an update, clear wins and that result is not recorded.
REQ-026 best_energy/best_seq SHALL hold their last values while best_valid=0; they are don't-care to consumers.
REQ-027 in_valid while not in IDLE SHALL be ignored; the input is not consumed.

Reset
REQ-028 rst SHALL force IDLE, in_ready=1 on the following cycle, out_valid=0, out_energy=0, out_seq=0, best_valid=0, best_energy=0, best_seq=0.
REQ-029 rst during RUN or DONE SHALL abandon the computation; no output handshake and no best-record update occurs.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and the max-energy width function used by REQ-023.
REQ-031 One sub-module, corr_lag, SHALL compute C_k combinationally from a sequence and a lag input; labs_energy SHALL instantiate it once.

Verification
REQ-032 N=8, in_seq=8'hFF -> out_valid 8 edges after accept, out_energy=140, out_seq=8'hFF.
REQ-033 N=8, feed 8'hFF, then 8'hAA (E=140, tie), then 8'hE4 (E=12) -> best_seq FF after the first two, then best_energy=12 and best_seq=E4.
REQ-034 N=7 override, in_seq=7'b1110010 (Barker) -> out_energy=3.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_valid and data stable, in_ready=0, second in_valid not consumed; out_ready=1 -> IDLE next cycle.
REQ-036 rst asserted mid-RUN -> next cycle in_ready=1, out_valid=0, best_valid=0; a fresh 8'hFF then yields 140.
REQ-037 clear_best on the same edge a result enters DONE -> best_valid=0 afterwards; the next result, of any value, is recorded.
